// File: rtl/lift_call_queue.sv
// Lift request front-end: debounces car and hall switches, latches floor requests, picks SCAN target.
// Latency: press to pending no more than 3+2*DEBOUNCE_CYCLES cycles; pending/cur_floor to req_* is 1 cycle (registered).
// Backpressure: none; req_valid/req_floor are level outputs held until req_ack clears the served floor.
module lift_call_queue #(
  parameter int NUM_FLOORS      = 8,
  parameter int FLOOR_W         = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*NUM_FLOORS-1:0] sw,
  input  logic [FLOOR_W-1:0]      cur_floor,
  input  logic                    doors_open,
  input  logic                    req_ack,
  output logic                    req_valid,
  output logic [FLOOR_W-1:0]      req_floor,
  output logic                    dir_up,
  output logic [NUM_FLOORS-1:0]   pending
);

  localparam int SW_W  = 2 * NUM_FLOORS;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  logic [SW_W-1:0]       sync_a;
  logic [SW_W-1:0]       sync_b;
  logic [SW_W-1:0]       samp;
  logic [SW_W-1:0]       db;
  logic [SW_W-1:0]       agree;
  logic [SW_W-1:0]       press;
  logic [CNT_W-1:0]      cnt;
  logic                  tick;
  logic [NUM_FLOORS-1:0] press_floor;
  logic [NUM_FLOORS-1:0] drop_mask;
  logic [NUM_FLOORS-1:0] set_mask;
  logic [NUM_FLOORS-1:0] clr_mask;

  state_t                state;
  state_t                state_nxt;
  logic                  dir_nxt;
  logic                  valid_nxt;
  logic [FLOOR_W-1:0]    floor_nxt;

  logic                  up_found;
  logic [FLOOR_W-1:0]    up_floor;
  logic                  dn_found;
  logic [FLOOR_W-1:0]    dn_floor;
  logic [FLOOR_W-1:0]    up_dist;
  logic [FLOOR_W-1:0]    dn_dist;
  logic                  take_up;

  // Two-flop synchroniser on every raw switch bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= sw;
      sync_b <= sync_a;
    end
  end

  // Shared sample-rate counter; one tick cycle per wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + CNT_W'(1);
  end

  assign tick  = (cnt == CNT_MAX);
  assign agree = ~(sync_b ^ samp);
  // A press is the debounced bit about to rise: two agreeing high samples while still low.
  assign press = tick ? (sync_b & samp & ~db) : '0;

  // Debounce: the stable value only follows the input when two consecutive tick samples agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp <= '0;
      db   <= '0;
    end else if (tick) begin
      samp <= sync_b;
      db   <= (agree & sync_b) | (~agree & db);
    end
  end

  // Car and hall presses for the same floor merge into one request bit.
  assign press_floor = press[NUM_FLOORS-1:0] | press[SW_W-1:NUM_FLOORS];
  assign drop_mask   = doors_open ? (NUM_FLOORS'(1) << cur_floor) : '0;
  assign set_mask    = press_floor & ~drop_mask;
  assign clr_mask    = (req_ack && req_valid) ? (NUM_FLOORS'(1) << req_floor) : '0;

  // Request latch; clearing is applied last so an ack beats a simultaneous press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else pending <= (pending | set_mask) & ~clr_mask;
  end

  // Nearest pending floor at-or-above and at-or-below the cabin.
  always_comb begin
    up_found = 1'b0;
    up_floor = '0;
    dn_found = 1'b0;
    dn_floor = '0;
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      if (pending[f] && (FLOOR_W'(f) >= cur_floor)) begin
        up_found = 1'b1;
        up_floor = FLOOR_W'(f);
      end
    end
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (pending[f] && (FLOOR_W'(f) <= cur_floor)) begin
        dn_found = 1'b1;
        dn_floor = FLOOR_W'(f);
      end
    end
  end

  assign up_dist = up_floor - cur_floor;
  assign dn_dist = cur_floor - dn_floor;
  assign take_up = up_found && (!dn_found || (up_dist <= dn_dist));

  // SCAN next-state and target; a reversal picks its new target in the same step.
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir_up;
    valid_nxt = req_valid;
    floor_nxt = req_floor;
    if (pending == '0) begin
      state_nxt = IDLE;
      valid_nxt = 1'b0;
    end else begin
      valid_nxt = 1'b1;
      case (state)
        IDLE: begin
          if (take_up) begin
            state_nxt = UP;
            dir_nxt   = 1'b1;
            floor_nxt = up_floor;
          end else begin
            state_nxt = DOWN;
            dir_nxt   = 1'b0;
            floor_nxt = dn_floor;
          end
        end
        UP: begin
          if (up_found) begin
            floor_nxt = up_floor;
          end else begin
            state_nxt = DOWN;
            dir_nxt   = 1'b0;
            floor_nxt = dn_floor;
          end
        end
        DOWN: begin
          if (dn_found) begin
            floor_nxt = dn_floor;
          end else begin
            state_nxt = UP;
            dir_nxt   = 1'b1;
            floor_nxt = up_floor;
          end
        end
        default: begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State and registered request outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dir_up    <= 1'b1;
      req_valid <= 1'b0;
      req_floor <= '0;
    end else begin
      state     <= state_nxt;
      dir_up    <= dir_nxt;
      req_valid <= valid_nxt;
      req_floor <= floor_nxt;
    end
  end

endmodule

// File: tb/tb_lift_call_queue.sv
// Bench for lift_call_queue: directed scenarios, then random presses/acks/floor moves
// checked against a request-level SCAN model through a scoreboard queue.
module tb_lift_call_queue;

  logic        clk;
  logic        rst_n;
  logic [15:0] sw;
  logic [2:0]  cur_floor;
  logic        doors_open;
  logic        req_ack;
  logic        req_valid;
  logic [2:0]  req_floor;
  logic        dir_up;
  logic [7:0]  pending;

  lift_call_queue #(
    .NUM_FLOORS(8),
    .FLOOR_W(3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .cur_floor(cur_floor),
    .doors_open(doors_open),
    .req_ack(req_ack),
    .req_valid(req_valid),
    .req_floor(req_floor),
    .dir_up(dir_up),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [7:0] pend;
    logic       vld;
    logic [2:0] flr;
    logic       dir;
  } exp_t;
  exp_t sbq[$];

  // Request-level reference model.
  logic [7:0] m_pend;
  bit         m_idle;
  bit         m_dir;
  bit         m_vld;
  logic [2:0] m_flr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Apply SCAN rules to the model for the current pending set and cabin floor.
  function automatic void model_eval(input int cur);
    int above[$];
    int below[$];
    if (m_pend == 8'h00) begin
      m_idle = 1'b1;
      m_vld  = 1'b0;
      return;
    end
    for (int f = 0; f < 8; f++) begin
      if (m_pend[f]) begin
        if (f >= cur) above.push_back(f);
        if (f <= cur) below.push_back(f);
      end
    end
    m_vld = 1'b1;
    if (m_idle) begin
      m_idle = 1'b0;
      m_dir  = (above.size() > 0) &&
               ((below.size() == 0) || ((above[0] - cur) <= (cur - below[below.size()-1])));
    end else if (m_dir && above.size() == 0) begin
      m_dir = 1'b0;
    end else if (!m_dir && below.size() == 0) begin
      m_dir = 1'b1;
    end
    m_flr = m_dir ? 3'(above[0]) : 3'(below[below.size()-1]);
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.pend = m_pend;
    e.vld  = m_vld;
    e.flr  = m_flr;
    e.dir  = m_dir;
    sbq.push_back(e);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    sw         = '0;
    req_ack    = 1'b0;
    doors_open = 1'b0;
    cycles(3);
    rst_n = 1'b1;
  endtask

  task automatic press(input logic [15:0] bits, input int hold);
    sw = sw | bits;
    cycles(hold);
    sw = sw & ~bits;
    cycles(16);
  endtask

  task automatic ack_pulse();
    req_ack = 1'b1;
    cycles(1);
    req_ack = 1'b0;
  endtask

  // Monitor: every change of the pending bitmap consumes one scoreboard entry;
  // the registered target is compared one cycle later.
  initial begin
    logic [7:0] last;
    exp_t       e;
    last = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        last = pending;
      end else if (pending !== last) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pending got=%0h was=%0h", pending, last);
        end else begin
          e = sbq.pop_front();
          check("sb_pending", pending, e.pend);
          @(negedge clk);
          check("sb_req_valid", req_valid, e.vld);
          check("sb_req_floor", req_floor, e.flr);
          check("sb_dir_up", dir_up, e.dir);
        end
        last = pending;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [7:0]  acc;
    logic [15:0] bits;
    int c0, c1, c2, lat, act, f, hall;

    rst_n      = 1'b0;
    sw         = 16'hFFFF;
    cur_floor  = 3'd0;
    doors_open = 1'b0;
    req_ack    = 1'b0;

    // Switches held through reset.
    cycles(3);
    check("rst_pending", pending, 8'h00);
    check("rst_req_valid", req_valid, 1'b0);
    check("rst_req_floor", req_floor, 3'd0);
    check("rst_dir_up", dir_up, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 11; k++) begin
      cycles(1);
      if (pending == 8'hFF) break;
    end
    check("held_through_reset", pending, 8'hFF);

    // Single car press above the cabin.
    do_reset();
    cur_floor = 3'd1;
    sw[5] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycles(1);
      if (pending == 8'h20 && req_valid && req_floor == 3'd5 && dir_up) break;
    end
    check("t2_pending", pending, 8'h20);
    check("t2_req_valid", req_valid, 1'b1);
    check("t2_req_floor", req_floor, 3'd5);
    check("t2_dir_up", dir_up, 1'b1);
    cycles(8);
    sw[5] = 1'b0;
    cycles(16);

    // Glitch shorter than the debounce period.
    do_reset();
    sw[3] = 1'b1;
    cycles(2);
    sw[3] = 1'b0;
    acc = '0;
    for (int k = 0; k < 40; k++) begin
      cycles(1);
      acc = acc | pending;
    end
    check("t3_short_pulse", acc, 8'h00);

    // Scan up past floor 1, then reverse after serving floor 6.
    do_reset();
    cur_floor = 3'd3;
    press(16'h0040, 14);
    press(16'h0002, 14);
    check("t4_pending", pending, 8'h42);
    check("t4_req_floor", req_floor, 3'd6);
    check("t4_dir_up", dir_up, 1'b1);
    cur_floor = 3'd6;
    cycles(2);
    ack_pulse();
    cycles(2);
    check("t4_ack_pending", pending, 8'h02);
    check("t4_rev_dir", dir_up, 1'b0);
    check("t4_rev_floor", req_floor, 3'd1);
    check("t4_rev_valid", req_valid, 1'b1);

    // Async reset mid-scan while heading down.
    cur_floor = 3'd1;
    cycles(2);
    ack_pulse();
    cycles(2);
    check("t6_drained", pending, 8'h00);
    cur_floor = 3'd5;
    press(16'h0090, 14);
    check("t6_pending", pending, 8'h90);
    check("t6_req_floor", req_floor, 3'd4);
    check("t6_dir_up", dir_up, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_async_pending", pending, 8'h00);
    check("t6_async_valid", req_valid, 1'b0);
    check("t6_async_dir", dir_up, 1'b1);
    cycles(1);
    rst_n = 1'b1;

    // Car+hall on one floor, then an ack landing on a re-press of the same floor.
    do_reset();
    cur_floor = 3'd0;
    c0 = cyc;
    c1 = -1;
    sw = 16'h0404;
    for (int k = 0; k < 14; k++) begin
      cycles(1);
      if (pending == 8'h04) begin
        c1 = cyc;
        break;
      end
    end
    check("t5_one_bit", pending, 8'h04);
    lat = c1 - c0;
    check("t5_press_latency_ok", (c1 >= 0) && (lat <= 11), 1'b1);
    while (cyc < c0 + 16) cycles(1);
    sw = '0;
    while (cyc < c0 + 40) cycles(1);
    c2 = cyc;
    sw[2] = 1'b1;
    if (c1 >= 0 && lat >= 1) begin
      while (cyc < c2 + lat - 1) cycles(1);
      ack_pulse();
      check("t5_clear_wins", pending, 8'h00);
      cycles(1);
      check("t5_valid_drop", req_valid, 1'b0);
    end
    cycles(12);
    sw = '0;
    cycles(16);

    // Random presses, acks and cabin moves against the model.
    do_reset();
    cur_floor = 3'($urandom_range(0, 7));
    m_pend = '0;
    m_idle = 1'b1;
    m_dir  = 1'b1;
    m_vld  = 1'b0;
    m_flr  = '0;
    cycles(2);
    mon_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      act = $urandom_range(0, 9);
      if (act < 5) begin
        f    = ($urandom_range(0, 3) == 0) ? int'(cur_floor) : $urandom_range(0, 7);
        hall = $urandom_range(0, 1);
        bits = 16'(1) << (f + 8 * hall);
        if ($urandom_range(0, 4) == 0) bits = bits | (16'(1) << f) | (16'(1) << (f + 8));
        doors_open = ($urandom_range(0, 2) == 0);
        if (!(doors_open && f == int'(cur_floor)) && !m_pend[f]) begin
          m_pend[f] = 1'b1;
          model_eval(int'(cur_floor));
          push_exp();
        end
        press(bits, 14);
        doors_open = 1'b0;
      end else if (act < 8) begin
        if (m_vld) begin
          m_pend[m_flr] = 1'b0;
          model_eval(int'(cur_floor));
          push_exp();
        end
        ack_pulse();
        cycles(4);
      end else begin
        cur_floor = 3'($urandom_range(0, 7));
        model_eval(int'(cur_floor));
        cycles(3);
      end
    end
    cycles(5);
    mon_en = 1'b0;
    check("sb_drained", sbq.size(), 0);
    check("final_pending", pending, m_pend);
    check("final_req_valid", req_valid, m_vld);
    check("final_req_floor", req_floor, m_flr);
    check("final_dir_up", dir_up, m_dir);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
